rx_sequencer: RTL and testbench

RX_SEQUENCER -- requirements
Module: rx_sequencer

---
 rtl/rx_sequencer.sv | 144 ++++++++++++++
 tb/tb_rx_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sequencer.sv
// UART-style serial receiver clocked at OVERSAMPLE x the baud rate.
// Frame: start bit, DATA_BITS data bits LSB first, one stop bit; mid-bit sampling.
// Rx_done / framing_err are single-cycle registered pulses; no backpressure.
module rx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                         Bclkx16_,
  input  logic                         reset,
  input  logic                         RxD,
  output logic [0:DATA_BITS-1]         data,
  output logic                         Rx_done,
  output logic                         framing_err,
  output logic                         rx_busy,
  output logic [$clog2(DATA_BITS)-1:0] bit_cnt
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(DATA_BITS);

  // START checks the line half a bit after the falling edge; DATA/STOP
  // sample on the last tick, which lands in the middle of each bit because
  // the DATA bit windows begin at the middle of the start bit.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             sync_q;
  logic                   rxs;
  logic [TW-1:0]          tick;
  logic                   tick_last;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   shift_en;
  logic                   bit_inc;
  logic                   bit_clr;
  logic                   stop_eval;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RxD};
    end
  end

  assign rxs       = sync_q[1];
  assign tick_last = (tick == TICK_LAST);

  // State register.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start detect, glitch reject, bit walk, stop check.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (tick == TICK_MID) state_nxt = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (tick_last && (bit_cnt == BIT_LAST)) state_nxt = STOP;
      end
      STOP: begin
        if (tick_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    rx_busy   = (state != IDLE);
    shift_en  = (state == DATA) && tick_last;
    bit_inc   = shift_en && (bit_cnt != BIT_LAST);
    bit_clr   = (state == START) && (state_nxt == DATA);
    stop_eval = (state == STOP) && tick_last;
  end

  // Tick counter: restarts on every state change, idles at zero in IDLE,
  // and wraps naturally every bit period inside DATA.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (state_nxt != state) begin
      tick <= '0;
    end else if (state != IDLE) begin
      tick <= tick + 1'b1;
    end
  end

  // Bit index of the data bit currently being received.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register: first received bit ends up in bit 0 after a full frame.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
    end
  end

  // Stop-bit verdict: publish the byte with Rx_done, or flag framing_err.
  always_ff @(posedge Bclkx16_ or posedge reset) begin
    if (reset) begin
      data        <= '0;
      Rx_done     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      Rx_done     <= stop_eval && rxs;
      framing_err <= stop_eval && !rxs;
      if (stop_eval && rxs) begin
        data <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// Bench for rx_sequencer: directed frames plus random traffic, every edge
// compared against a frame-level model of the receiver computed from the
// recorded line waveform.
module tb_rx_sequencer;

  logic       Bclkx16_;
  logic       reset;
  logic       RxD;
  logic [0:7] data;
  logic       Rx_done;
  logic       framing_err;
  logic       rx_busy;
  logic [2:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  // line_q[n]: RxD level present at recorded edge n; obs_q[n]: outputs after it
  logic        line_q[$];
  logic [13:0] obs_q[$];

  rx_sequencer #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .Bclkx16_    (Bclkx16_),
    .reset       (reset),
    .RxD         (RxD),
    .data        (data),
    .Rx_done     (Rx_done),
    .framing_err (framing_err),
    .rx_busy     (rx_busy),
    .bit_cnt     (bit_cnt)
  );

  initial begin
    Bclkx16_ = 1'b0;
    forever #5 Bclkx16_ = ~Bclkx16_;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] pk(input logic dn, input logic er, input logic bz,
                                     input logic [2:0] bc, input logic [7:0] d);
    return {dn, er, bz, bc, d};
  endfunction

  // Synchronized line as seen by the receiver at edge n (two edges late).
  function automatic logic rxs_at(input int n);
    if (n < 2 || (n - 2) >= line_q.size()) return 1'b1;
    return line_q[n-2];
  endfunction

  // Drive one bit-clock cycle; called and returning at a falling edge.
  task automatic step(input logic v);
    RxD = v;
    @(posedge Bclkx16_);
    #1;
    line_q.push_back(v);
    obs_q.push_back({Rx_done, framing_err, rx_busy, bit_cnt, data});
    @(negedge Bclkx16_);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Whole frame is 160 cycles: 16 start, 8 x 16 data, 16 stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nmax);
    logic v;
    for (int i = 0; i < 160 && i < nmax; i++) begin
      if (i < 16)       v = 1'b0;
      else if (i < 144) v = b[(i - 16) / 16];
      else              v = stop;
      step(v);
    end
  endtask

  function automatic int find_pulse(input int from, input int bitpos);
    for (int i = from; i < obs_q.size(); i++)
      if (obs_q[i][bitpos] === 1'b1) return i;
    return -1;
  endfunction

  // Reference: a start is seen on the first edge where the synchronized line
  // is low; mid-start check 8 edges later, data bit k sampled 24+16k edges
  // after detection, stop 152 edges after; the receiver looks for a new start
  // one edge after that verdict.
  task automatic compare_segment(input logic [7:0] data0, input logic [2:0] bc0);
    int          n_edges;
    int          n;
    int          s;
    int          exp_done;
    int          exp_err;
    int          got_done;
    int          got_err;
    logic [7:0]  d;
    logic [7:0]  byte_v;
    logic [2:0]  bc;
    logic [13:0] exp_a[];
    n_edges  = line_q.size();
    exp_a    = new[n_edges];
    d        = data0;
    bc       = bc0;
    n        = 0;
    exp_done = 0;
    exp_err  = 0;
    while (n < n_edges) begin
      if (rxs_at(n) == 1'b1) begin
        exp_a[n] = pk(1'b0, 1'b0, 1'b0, bc, d);
        n++;
      end else begin
        s = n;
        for (int e = s; e < s + 8 && e < n_edges; e++) exp_a[e] = pk(1'b0, 1'b0, 1'b1, bc, d);
        if (s + 8 >= n_edges) break;
        if (rxs_at(s + 8) == 1'b1) begin
          exp_a[s+8] = pk(1'b0, 1'b0, 1'b0, bc, d);
          n = s + 9;
        end else begin
          for (int k = 0; k < 8; k++) byte_v[k] = rxs_at(s + 24 + 16 * k);
          for (int e = s + 8; e < s + 152 && e < n_edges; e++) begin
            bc = 3'(((e - s - 8) / 16 > 7) ? 7 : (e - s - 8) / 16);
            exp_a[e] = pk(1'b0, 1'b0, 1'b1, bc, d);
          end
          if (s + 152 >= n_edges) break;
          if (rxs_at(s + 152) == 1'b1) begin
            d = byte_v;
            exp_a[s+152] = pk(1'b1, 1'b0, 1'b0, bc, d);
            exp_done++;
          end else begin
            exp_a[s+152] = pk(1'b0, 1'b1, 1'b0, bc, d);
            exp_err++;
          end
          n = s + 153;
        end
      end
    end
    got_done = 0;
    got_err  = 0;
    for (int i = 0; i < n_edges; i++) begin
      chk($sformatf("edge%0d", i), 32'(obs_q[i]), 32'(exp_a[i]));
      if (obs_q[i][13] === 1'b1) got_done++;
      if (obs_q[i][12] === 1'b1) got_err++;
    end
    chk("n_done", got_done, exp_done);
    chk("n_err", got_err, exp_err);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"}, 32'(data), 32'h00);
    chk({tag, "_done"}, 32'(Rx_done), 32'h0);
    chk({tag, "_err"}, 32'(framing_err), 32'h0);
    chk({tag, "_busy"}, 32'(rx_busy), 32'h0);
    chk({tag, "_bitcnt"}, 32'(bit_cnt), 32'h0);
  endtask

  initial begin
    int e_a5;
    int e_3c;
    int e_01;
    int e_lo;
    int idx;
    int idx2;
    int kind;
    int gap;
    logic [7:0] rb;

    reset = 1'b1;
    RxD   = 1'b1;
    #1;
    check_reset_vals("rst0");
    repeat (3) @(posedge Bclkx16_);
    #1;
    check_reset_vals("rst1");
    @(negedge Bclkx16_);
    reset = 1'b0;

    // ---- segment 1: directed frames, then a frame cut short by reset
    idle(5);
    e_a5 = line_q.size();
    send_frame(8'hA5, 1'b1, 160);
    idle(10);
    for (int i = 0; i < 4; i++) step(1'b0);
    idle(30);
    e_3c = line_q.size();
    send_frame(8'h3C, 1'b0, 160);
    idle(20);
    e_01 = line_q.size();
    send_frame(8'h01, 1'b1, 160);
    send_frame(8'hFF, 1'b1, 160);
    idle(20);
    send_frame(8'h55, 1'b1, 80);

    idx = find_pulse(e_a5, 13);
    chk("a5_latency", idx - e_a5, 154);
    chk("a5_data", (idx >= 0) ? 32'(obs_q[idx][7:0]) : 32'hdead, 32'hA5);
    chk("a5_width", (idx >= 0 && idx + 1 < obs_q.size()) ? 32'(obs_q[idx+1][13]) : 32'h1, 32'h0);
    idx = find_pulse(e_3c, 12);
    chk("3c_err_latency", idx - e_3c, 154);
    chk("3c_data_kept", (idx >= 0) ? 32'(obs_q[idx][7:0]) : 32'hdead, 32'hA5);
    idx  = find_pulse(e_01, 13);
    idx2 = (idx >= 0) ? find_pulse(idx + 1, 13) : -1;
    chk("b2b_spacing", idx2 - idx, 160);
    chk("b2b_first", (idx >= 0) ? 32'(obs_q[idx][7:0]) : 32'hdead, 32'h01);
    chk("b2b_second", (idx2 >= 0) ? 32'(obs_q[idx2][7:0]) : 32'hdead, 32'hFF);
    chk("mid_bitcnt", 32'(bit_cnt), 32'd4);
    compare_segment(8'h00, 3'd0);
    line_q.delete();
    obs_q.delete();

    // asynchronous reset in the middle of data bit 4
    #2;
    reset = 1'b1;
    RxD   = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(posedge Bclkx16_);
    @(negedge Bclkx16_);
    reset = 1'b0;

    // ---- segment 2: fresh frame, stuck-low line, random traffic
    send_frame(8'h55, 1'b1, 160);
    idle(10);
    e_lo = line_q.size();
    for (int i = 0; i < 480; i++) step(1'b0);
    idle(200);
    idx = find_pulse(0, 13);
    chk("post_rst_55", (idx >= 0) ? 32'(obs_q[idx][7:0]) : 32'hdead, 32'h55);
    idx  = find_pulse(e_lo, 12);
    idx2 = (idx >= 0) ? find_pulse(idx + 1, 12) : -1;
    chk("stuck_err_period", idx2 - idx, 153);
    chk("stuck_data_kept", (idx2 >= 0) ? 32'(obs_q[idx2][7:0]) : 32'hdead, 32'h55);

    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 9);
      rb   = 8'($urandom);
      if (kind == 0) begin
        for (int i = 0; i < $urandom_range(1, 6); i++) step(1'b0);
        idle(20);
      end else if (kind == 1) begin
        send_frame(rb, 1'b0, 160);
        idle(20);
      end else begin
        send_frame(rb, 1'b1, 160);
        gap = $urandom_range(0, 12);
        idle(gap);
      end
    end
    idle(20);
    compare_segment(8'h00, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
